// File: rtl/dds_pkg.sv
// Shared constants for the DDS waveform generator: default widths, LFSR seed/taps
// and quarter-wave sine table geometry.
package dds_pkg;

   localparam int unsigned PHASE_W_DEF = 24;
   localparam int unsigned OUT_W_DEF   = 12;
   localparam int unsigned P_W         = 12;
   localparam int unsigned LFSR_W      = 16;
   localparam int unsigned QLUT_AW     = 8;
   localparam int unsigned QLUT_DW     = 11;

   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Feedback taps at bits 15, 13, 12 and 10.
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/sine_qlut.sv
// Combinational quarter-wave sine table: val_c = round(2047*sin(pi*(2*idx+1)/1024)).
// Entries are produced at elaboration by a fixed-point Taylor series.
module sine_qlut
   import dds_pkg::*;
(
   input  logic [QLUT_AW-1:0] idx,
   output logic [QLUT_DW-1:0] val_c
);

   localparam longint PI_Q30 = 64'sd3373259426;

   // Q30 fixed-point sine of the table angle, rounded to 11 bits.
   function automatic logic [QLUT_DW-1:0] qsin(input int unsigned i);
      longint x;
      longint x2;
      longint term;
      longint sum;
      x    = (PI_Q30 * longint'(2 * i + 1)) / 64'sd1024;
      x2   = (x * x) >>> 30;
      term = x;
      sum  = x;
      for (int n = 1; n < 10; n++) begin
         term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
         sum  = sum + term;
      end
      return QLUT_DW'((sum * 64'sd2047 + (64'sd1 <<< 29)) >>> 30);
   endfunction

   logic [QLUT_DW-1:0] tbl [2**QLUT_AW];

   for (genvar g = 0; g < 2**QLUT_AW; g++) begin : g_tbl
      localparam logic [QLUT_DW-1:0] ENTRY = qsin(g);
      assign tbl[g] = ENTRY;
   end

   assign val_c = tbl[idx];

endmodule

// File: rtl/dds_wavegen.sv
// Direct digital synthesis waveform generator: phase accumulator driving registered
// sine, sawtooth, pulse, triangle and LFSR-noise samples.
module dds_wavegen
   import dds_pkg::*;
#(
   parameter int unsigned PHASE_W = PHASE_W_DEF,
   parameter int unsigned OUT_W   = OUT_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic               phase_clr,
   input  logic [PHASE_W-1:0] freq_word,
   input  logic [OUT_W-1:0]   duty,
   output logic [OUT_W-1:0]   sine,
   output logic [OUT_W-1:0]   saw,
   output logic [OUT_W-1:0]   pulse,
   output logic [OUT_W-1:0]   traing,
   output logic [OUT_W-1:0]   noi,
   output logic               out_valid
);

   localparam logic [P_W-1:0] MID = 12'h800;

   logic [PHASE_W-1:0] acc;
   logic [LFSR_W-1:0]  lfsr;
   logic [PHASE_W:0]   acc_sum_c;
   logic               wrap_c;
   logic               fb_c;
   logic [P_W-1:0]     p_c;
   logic [1:0]         quad_c;
   logic [QLUT_AW-1:0] idx_c;
   logic [QLUT_DW-1:0] mag_c;
   logic [P_W-1:0]     sine_c;
   logic [P_W-1:0]     tri_base_c;
   logic [P_W-1:0]     tri_c;
   logic [P_W-1:0]     pulse_c;

   assign acc_sum_c = {1'b0, acc} + {1'b0, freq_word};
   // A cleared edge never counts as a wrap, so it cannot step the LFSR.
   assign wrap_c    = acc_sum_c[PHASE_W] & en & ~phase_clr;
   assign fb_c      = ^(lfsr & LFSR_TAPS);
   assign p_c       = acc[PHASE_W-1 -: P_W];

   // Quadrant folding onto the quarter-wave table.
   assign quad_c = p_c[11:10];
   assign idx_c  = quad_c[0] ? ~p_c[9:2] : p_c[9:2];

   sine_qlut u_qlut (
      .idx   (idx_c),
      .val_c (mag_c)
   );

   assign sine_c     = quad_c[1] ? (MID - P_W'(mag_c)) : (MID + P_W'(mag_c));
   assign tri_base_c = {p_c[10:0], 1'b0};
   assign tri_c      = p_c[11] ? ~tri_base_c : tri_base_c;
   assign pulse_c    = (p_c < duty) ? '1 : '0;

   // Phase accumulator and noise LFSR.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc  <= '0;
         lfsr <= LFSR_SEED;
      end else begin
         if (phase_clr) begin
            acc <= '0;
         end else if (en) begin
            acc <= acc_sum_c[PHASE_W-1:0];
         end
         if (wrap_c) begin
            lfsr <= {lfsr[LFSR_W-2:0], fb_c};
         end
      end
   end

   // Sample registers load from the pre-edge phase on enabled edges.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sine      <= MID;
         saw       <= '0;
         pulse     <= '0;
         traing    <= '0;
         noi       <= '0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= en;
         if (en) begin
            sine   <= sine_c;
            saw    <= p_c;
            pulse  <= pulse_c;
            traing <= tri_c;
            noi    <= lfsr[P_W-1:0];
         end
      end
   end

endmodule

// File: tb/tb_dds_wavegen.sv
// Self-checking bench for dds_wavegen: directed vector table, randomized run against
// an arithmetic reference model, and an asynchronous mid-run reset sequence.
module tb_dds_wavegen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        phase_clr;
   logic [23:0] freq_word;
   logic [11:0] duty;
   logic [11:0] sine;
   logic [11:0] saw;
   logic [11:0] pulse;
   logic [11:0] traing;
   logic [11:0] noi;
   logic        out_valid;

   int passed = 0;
   int total  = 0;

   int unsigned m_acc;
   int m_lfsr, m_sine, m_saw, m_pulse, m_tri, m_noi, m_valid;

   typedef struct {
      logic        en;
      logic        clr;
      logic [23:0] fw;
      logic [11:0] duty;
      int          saw;
      int          pulse;
      int          tri_v;
      int          sine;
      int          noi;
      int          valid;
   } vec_t;

   vec_t vecs[$];

   dds_wavegen #(.PHASE_W(24), .OUT_W(12)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .phase_clr (phase_clr),
      .freq_word (freq_word),
      .duty      (duty),
      .sine      (sine),
      .saw       (saw),
      .pulse     (pulse),
      .traing    (traing),
      .noi       (noi),
      .out_valid (out_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: actual %0h required %0h", name, act, exp);
   endtask

   function automatic int sine_ref(input int p);
      int  q;
      int  r;
      int  i;
      real t;
      int  ti;
      q  = p / 1024;
      r  = (p % 1024) / 4;
      i  = (q % 2 == 1) ? 255 - r : r;
      t  = 2047.0 * $sin(3.14159265358979323846 * real'(2 * i + 1) / 1024.0);
      ti = $rtoi(t + 0.5);
      return (q < 2) ? 2048 + ti : 2048 - ti;
   endfunction

   task automatic model_reset();
      m_acc   = 0;
      m_lfsr  = 'hACE1;
      m_sine  = 2048;
      m_saw   = 0;
      m_pulse = 0;
      m_tri   = 0;
      m_noi   = 0;
      m_valid = 0;
   endtask

   task automatic model_edge(input int e, input int c, input int unsigned fw, input int d);
      int     p;
      int     fb;
      longint sum;
      p   = int'(m_acc / 4096);
      sum = longint'(m_acc) + longint'(fw);
      if (e != 0) begin
         m_saw   = p;
         m_pulse = (p < d) ? 4095 : 0;
         m_tri   = (p < 2048) ? 2 * p : 4095 - 2 * (p - 2048);
         m_sine  = sine_ref(p);
         m_noi   = m_lfsr % 4096;
      end
      m_valid = e;
      if (c != 0) m_acc = 0;
      else if (e != 0) m_acc = int'(sum % 64'd16777216);
      if (e != 0 && c == 0 && sum >= 64'd16777216) begin
         fb     = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
         m_lfsr = (m_lfsr * 2 + fb) % 65536;
      end
   endtask

   task automatic step(input logic e, input logic c, input logic [23:0] fw, input logic [11:0] d);
      en        = e;
      phase_clr = c;
      freq_word = fw;
      duty      = d;
      @(posedge clk);
      model_edge(int'(e), int'(c), int'(fw), int'(d));
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, "_saw"},   int'(saw),       m_saw);
      chk({tag, "_pulse"}, int'(pulse),     m_pulse);
      chk({tag, "_tri"},   int'(traing),    m_tri);
      chk({tag, "_sine"},  int'(sine),      m_sine);
      chk({tag, "_noi"},   int'(noi),       m_noi);
      chk({tag, "_valid"}, int'(out_valid), m_valid);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_sine"},  int'(sine),      'h800);
      chk({tag, "_saw"},   int'(saw),       0);
      chk({tag, "_pulse"}, int'(pulse),     0);
      chk({tag, "_tri"},   int'(traing),    0);
      chk({tag, "_noi"},   int'(noi),       0);
      chk({tag, "_valid"}, int'(out_valid), 0);
   endtask

   function automatic vec_t mk(input logic e, input logic c, input logic [23:0] fw,
                               input logic [11:0] d, input int s, input int pu,
                               input int tr, input int si, input int no, input int va);
      vec_t v;
      v.en = e; v.clr = c; v.fw = fw; v.duty = d;
      v.saw = s; v.pulse = pu; v.tri_v = tr; v.sine = si; v.noi = no; v.valid = va;
      return v;
   endfunction

   initial begin
      rst = 1'b0; en = 1'b0; phase_clr = 1'b0; freq_word = '0; duty = '0;
      model_reset();

      // Directed vectors from reset; sine of -1 means not checked for that row.
      vecs.push_back(mk(1, 0, 24'h001000, 12'h400, 'h000, 'hFFF, 'h000, 'h806, 'hCE1, 1));
      vecs.push_back(mk(1, 0, 24'h001000, 12'h400, 'h001, 'hFFF, 'h002, 'h806, 'hCE1, 1));
      vecs.push_back(mk(1, 0, 24'h800000, 12'h400, 'h002, 'hFFF, 'h004, 'h806, 'hCE1, 1));
      vecs.push_back(mk(0, 0, 24'h123456, 12'h000, 'h002, 'hFFF, 'h004, 'h806, 'hCE1, 0));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h400, 'h802, 'h000, 'hFFB, 'h7FA, 'hCE1, 1));
      vecs.push_back(mk(1, 0, 24'h7FE000, 12'h400, 'h802, 'h000, 'hFFB, 'h7FA, 'hCE1, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h400, 'h000, 'hFFF, 'h000, 'h806, 'h9C3, 1));
      vecs.push_back(mk(1, 1, 24'h400000, 12'h400, 'h000, 'hFFF, 'h000, 'h806, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h500000, 12'h400, 'h000, 'hFFF, 'h000, 'h806, 'h9C3, 1));
      vecs.push_back(mk(1, 1, 24'hC00000, 12'h400, 'h500, 'h000, 'hA00, -1,    'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h400, 'h000, 'hFFF, 'h000, 'h806, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'hFFF000, 12'hFFF, 'h000, 'hFFF, 'h000, 'h806, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'hFFF, 'hFFF, 'h000, 'h001, 'h7FA, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h000, 'hFFF, 'h000, 'h001, 'h7FA, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h001000, 12'hFFF, 'hFFF, 'h000, 'h001, 'h7FA, 'h9C3, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h000, 'h000, 'h000, 'h000, 'h806, 'h387, 1));
      vecs.push_back(mk(1, 0, 24'h7FF000, 12'h800, 'h000, 'hFFF, 'h000, 'h806, 'h387, 1));
      vecs.push_back(mk(1, 0, 24'h001000, 12'h800, 'h7FF, 'hFFF, 'hFFE, 'h806, 'h387, 1));
      vecs.push_back(mk(1, 0, 24'h000000, 12'h800, 'h800, 'h000, 'hFFF, 'h7FA, 'h387, 1));

      #1 rst = 1'b1;
      #1 chk_reset("init_rst");
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[k]) begin
         step(vecs[k].en, vecs[k].clr, vecs[k].fw, vecs[k].duty);
         chk($sformatf("vec%0d_saw", k),   int'(saw),       vecs[k].saw);
         chk($sformatf("vec%0d_pulse", k), int'(pulse),     vecs[k].pulse);
         chk($sformatf("vec%0d_tri", k),   int'(traing),    vecs[k].tri_v);
         if (vecs[k].sine >= 0) chk($sformatf("vec%0d_sine", k), int'(sine), vecs[k].sine);
         chk($sformatf("vec%0d_noi", k),   int'(noi),       vecs[k].noi);
         chk($sformatf("vec%0d_valid", k), int'(out_valid), vecs[k].valid);
      end

      // Randomized run against the reference model.
      for (int n = 0; n < 500; n++) begin
         logic [23:0] fw;
         case ($urandom_range(0, 3))
            0:       fw = 24'($urandom);
            1:       fw = 24'($urandom_range(0, 'h3000));
            2:       fw = 24'h400000;
            default: fw = 24'h800000;
         endcase
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
              fw, 12'($urandom));
         chk_model($sformatf("rnd%0d", n));
      end

      // Asynchronous reset between clock edges, then enable held low.
      #2 rst = 1'b1;
      #1 chk_reset("async_rst");
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      for (int n = 0; n < 3; n++) begin
         step(1'b0, 1'b0, 24'($urandom), 12'($urandom));
         chk_model($sformatf("hold%0d", n));
      end
      step(1'b1, 1'b0, 24'h001000, 12'h400);
      chk("post_rst_saw",   int'(saw),       0);
      chk("post_rst_sine",  int'(sine),      'h806);
      chk("post_rst_noi",   int'(noi),       'hCE1);
      chk("post_rst_pulse", int'(pulse),     'hFFF);
      chk("post_rst_valid", int'(out_valid), 1);
      for (int n = 0; n < 40; n++) begin
         step(1'b1, 1'b0, 24'h400000, 12'h800);
         chk_model($sformatf("tail%0d", n));
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
